// File: rtl/ws_seq_pkg.sv
// Shared definitions for the ws2812b frame sequencer: register map, CTRL/status bits,
// FSM states and the {G,R,B} pixel layout.
package ws_seq_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_PTR    = 4'd1;
  localparam logic [3:0] ADDR_G      = 4'd2;
  localparam logic [3:0] ADDR_R      = 4'd3;
  localparam logic [3:0] ADDR_B      = 4'd4;
  localparam logic [3:0] ADDR_COUNT  = 4'd5;
  localparam logic [3:0] ADDR_BRIGHT = 4'd6;

  // CTRL write bits
  localparam int CTRL_START = 0;
  localparam int CTRL_LATCH = 1;
  localparam int CTRL_LOOP  = 2;
  localparam int CTRL_STOP  = 3;

  // CTRL read bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_LOOP = 2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/ws_seq_scale.sv
// Per-channel brightness scaler: scaled = (c * (bright + 1)) >> 8, purely combinational.
// bright = 0xFF passes c through unchanged; bright = 0x00 yields 0.
module ws_seq_scale (
  input  logic [7:0] c,
  input  logic [7:0] bright,
  output logic [7:0] scaled
);

  logic [15:0] prod;

  assign prod   = 16'(c) * 16'({1'b0, bright} + 9'd1);
  assign scaled = 8'(prod >> 8);

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Frame buffer plus pixel sequencer feeding one ws2812b core; start-to-px_valid is 1 cycle,
// and the core's px_ready handshake paces every pixel. Brightness scaling under WS_SEQ_BRIGHTNESS_EN.
module ws2812b_frame_sequencer
  import ws_seq_pkg::*;
#(
  parameter int NUM_PIXELS = 16,
  parameter int IDX_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  address,
  input  logic        data_write,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [23:0] px_data,
  output logic        px_valid,
  output logic        px_latch,
  input  logic        px_ready,
  output logic        busy
);

  localparam int               FB_AW   = $clog2(NUM_PIXELS);
  localparam logic [7:0]       NPX8    = 8'(NUM_PIXELS);
  localparam logic [IDX_W:0]   NPX_C   = (IDX_W+1)'(NUM_PIXELS);
  localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(NUM_PIXELS - 1);
  localparam logic [IDX_W-1:0] ONE_I   = 1;
  localparam logic [IDX_W:0]   ONE_C   = 1;

  state_t state, state_nxt;

  pixel_t           fb [NUM_PIXELS];
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   count;
  logic [7:0]       g_stage, r_stage;
  logic             done, loop_r, latch_en, stop_req;

  logic wr_ctrl, start_wr, last;
  logic frame_start, empty_start, idx_adv, frame_restart, frame_end;
  pixel_t fb_rd, px_pix;

  assign busy     = (state != S_IDLE);
  assign wr_ctrl  = data_write && (address == ADDR_CTRL);
  assign start_wr = wr_ctrl && data_in[CTRL_START];
  assign last     = (({1'b0, idx} + ONE_C) == count);
  assign fb_rd    = fb[idx[FB_AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    px_valid      = 1'b0;
    frame_start   = 1'b0;
    empty_start   = 1'b0;
    idx_adv       = 1'b0;
    frame_restart = 1'b0;
    frame_end     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_wr) begin
          if (count != '0) begin
            frame_start = 1'b1;
            state_nxt   = S_ISSUE;
          end else begin
            empty_start = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (px_ready) begin
          px_valid  = 1'b1;
          state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!px_ready) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (px_ready) begin
          state_nxt = S_ISSUE;
          if (!last) begin
            idx_adv = 1'b1;
          end else if (loop_r && !stop_req) begin
            frame_restart = 1'b1;
          end else begin
            frame_end = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign px_latch = px_valid && latch_en && last;
  assign px_data  = px_valid ? px_pix : '0;

`ifdef WS_SEQ_BRIGHTNESS_EN
  logic [7:0] bright;
  logic [7:0] sc_g, sc_r, sc_b;

  ws_seq_scale u_scale_g (.c(fb_rd.g), .bright(bright), .scaled(sc_g));
  ws_seq_scale u_scale_r (.c(fb_rd.r), .bright(bright), .scaled(sc_r));
  ws_seq_scale u_scale_b (.c(fb_rd.b), .bright(bright), .scaled(sc_b));

  assign px_pix = {sc_g, sc_r, sc_b};

  always_ff @(posedge clk) begin
    if (!rst_n)                                      bright <= 8'hFF;
    else if (data_write && address == ADDR_BRIGHT)   bright <= data_in;
  end
`else
  assign px_pix = fb_rd;
`endif

  // Sequencer bookkeeping and register file; buffer-facing registers freeze while busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      ptr      <= '0;
      count    <= NPX_C;
      g_stage  <= '0;
      r_stage  <= '0;
      done     <= 1'b0;
      loop_r   <= 1'b0;
      latch_en <= 1'b0;
      stop_req <= 1'b0;
    end else begin
      if (frame_start) begin
        idx      <= '0;
        latch_en <= data_in[CTRL_LATCH];
        loop_r   <= data_in[CTRL_LOOP] & ~data_in[CTRL_STOP];
        done     <= 1'b0;
        stop_req <= 1'b0;
      end
      if (empty_start)   done <= 1'b1;
      if (idx_adv)       idx  <= idx + ONE_I;
      if (frame_restart) idx  <= '0;

      if (frame_end) begin
        done     <= 1'b1;
        stop_req <= 1'b0;
      end else if (busy && wr_ctrl && data_in[CTRL_STOP]) begin
        stop_req <= 1'b1;
      end

      if (data_write && !busy) begin
        case (address)
          ADDR_PTR:   ptr     <= IDX_W'(data_in % NPX8);
          ADDR_G:     g_stage <= data_in;
          ADDR_R:     r_stage <= data_in;
          ADDR_B:     ptr     <= (ptr == PTR_MAX) ? '0 : ptr + ONE_I;
          ADDR_COUNT: count   <= (data_in > NPX8) ? NPX_C : (IDX_W+1)'(data_in);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (data_write && !busy && address == ADDR_B)
      fb[ptr[FB_AW-1:0]] <= '{g: g_stage, r: r_stage, b: data_in};
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_CTRL: begin
        data_out[STAT_BUSY] = busy;
        data_out[STAT_DONE] = done;
        data_out[STAT_LOOP] = loop_r;
      end
      ADDR_PTR:    data_out = 8'(ptr);
      ADDR_G:      data_out = g_stage;
      ADDR_R:      data_out = r_stage;
      ADDR_COUNT:  data_out = 8'(count);
`ifdef WS_SEQ_BRIGHTNESS_EN
      ADDR_BRIGHT: data_out = bright;
`endif
      default:     data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Directed bench for ws2812b_frame_sequencer with a behavioural core model that drops
// px_ready one cycle after each px_valid and raises it again 30 cycles later.
module tb_ws2812b_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  address;
  logic        data_write;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [23:0] px_data;
  logic        px_valid;
  logic        px_latch;
  logic        px_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int          pulse_cnt = 0;
  logic [23:0] pix_log   [64];
  logic        latch_log [64];
  int          rdy_cnt;

  ws2812b_frame_sequencer #(.NUM_PIXELS(16), .IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_write(data_write),
    .data_in(data_in), .data_out(data_out), .px_data(px_data), .px_valid(px_valid),
    .px_latch(px_latch), .px_ready(px_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model
  always @(posedge clk) begin
    if (!rst_n) begin
      px_ready <= 1'b1;
      rdy_cnt  <= 0;
    end else if (px_ready && px_valid) begin
      px_ready <= 1'b0;
      rdy_cnt  <= 30;
    end else if (!px_ready) begin
      if (rdy_cnt == 1) px_ready <= 1'b1;
      rdy_cnt <= rdy_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (px_valid && pulse_cnt < 64) begin
      pix_log[pulse_cnt]   = px_data;
      latch_log[pulse_cnt] = px_latch;
      pulse_cnt            = pulse_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_pulses(input string tag, input int target, input int max);
    int n = 0;
    while (pulse_cnt < target && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, pulse_cnt >= target}, 32'd1);
  endtask

  logic [7:0] rv;
  int base;

  initial begin
    rst_n      = 1'b0;
    address    = 4'd0;
    data_write = 1'b0;
    data_in    = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_px_valid", {31'd0, px_valid}, 32'd0);
    chk("rst_px_data", {8'd0, px_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rd(4'd0, rv); chk("rst_ctrl", {24'd0, rv}, 32'h00);
    rd(4'd5, rv); chk("rst_count", {24'd0, rv}, 32'h10);
    rd(4'd1, rv); chk("rst_ptr", {24'd0, rv}, 32'h00);
`ifdef WS_SEQ_BRIGHTNESS_EN
    rd(4'd6, rv); chk("rst_bright", {24'd0, rv}, 32'hFF);
`else
    rd(4'd6, rv); chk("rst_bright", {24'd0, rv}, 32'h00);
`endif

    // COUNT=0 start: done immediately, never busy, no pulse
    wr(4'd5, 8'd0);
    rd(4'd5, rv); chk("count_zero", {24'd0, rv}, 32'h00);
    wr(4'd0, 8'h01);
    chk("empty_valid", {31'd0, px_valid}, 32'd0);
    rd(4'd0, rv); chk("empty_ctrl", {24'd0, rv}, 32'h02);
    repeat (5) @(negedge clk);
    chk("empty_pulses", pulse_cnt, 0);

    // PTR wrap by modulo, COUNT clamp
    wr(4'd1, 8'h13);
    rd(4'd1, rv); chk("ptr_mod", {24'd0, rv}, 32'h03);
    wr(4'd5, 8'h40);
    rd(4'd5, rv); chk("count_clamp", {24'd0, rv}, 32'h10);

    // Load three pixels and send one latched frame
    wr(4'd1, 8'h00);
    wr(4'd2, 8'h10); wr(4'd3, 8'h20); wr(4'd4, 8'h30);
    wr(4'd2, 8'h40); wr(4'd3, 8'h50); wr(4'd4, 8'h60);
    wr(4'd2, 8'h70); wr(4'd3, 8'h80); wr(4'd4, 8'h90);
    rd(4'd1, rv); chk("ptr_after_load", {24'd0, rv}, 32'h03);
    wr(4'd5, 8'd3);
    base = pulse_cnt;
    wr(4'd0, 8'h03);
    chk("first_valid_latency", {31'd0, px_valid}, 32'd1);
    chk("first_busy", {31'd0, busy}, 32'd1);
    wait_idle("frame1_timeout", 500);
    chk("frame1_pulses", pulse_cnt - base, 3);
    chk("frame1_px0", {8'd0, pix_log[base]},   32'h102030);
    chk("frame1_px1", {8'd0, pix_log[base+1]}, 32'h405060);
    chk("frame1_px2", {8'd0, pix_log[base+2]}, 32'h708090);
    chk("frame1_latch", {29'd0, latch_log[base], latch_log[base+1], latch_log[base+2]}, 32'b001);
    rd(4'd0, rv); chk("frame1_ctrl", {24'd0, rv}, 32'h02);

    // Loop mode, stop requested during the 5th pixel
    wr(4'd5, 8'd2);
    base = pulse_cnt;
    wr(4'd0, 8'h07);
    wait_pulses("loop_wait5", base + 5, 1000);
    wr(4'd0, 8'h08);
    wait_idle("loop_timeout", 500);
    chk("loop_pulses", pulse_cnt - base, 6);
    chk("loop_latch", {26'd0, latch_log[base], latch_log[base+1], latch_log[base+2],
        latch_log[base+3], latch_log[base+4], latch_log[base+5]}, 32'b010101);
    chk("loop_px5", {8'd0, pix_log[base+5]}, 32'h405060);
    rd(4'd0, rv); chk("loop_status", {30'd0, rv[1:0]}, 32'b10);
    repeat (40) @(negedge clk);
    chk("loop_no_7th", pulse_cnt - base, 6);

    // Buffer/count writes and a second start while busy are ignored
    wr(4'd1, 8'h00);
    wr(4'd5, 8'd3);
    base = pulse_cnt;
    wr(4'd0, 8'h01);
    wr(4'd2, 8'hEE); wr(4'd3, 8'hEE); wr(4'd4, 8'hEE);
    wr(4'd1, 8'h05); wr(4'd5, 8'h01); wr(4'd0, 8'h01);
    chk("busy_during_writes", {31'd0, busy}, 32'd1);
    wait_idle("busyw_timeout", 500);
    chk("busyw_pulses", pulse_cnt - base, 3);
    rd(4'd1, rv); chk("busyw_ptr", {24'd0, rv}, 32'h00);
    rd(4'd5, rv); chk("busyw_count", {24'd0, rv}, 32'h03);
    base = pulse_cnt;
    wr(4'd0, 8'h01);
    wait_idle("rerun_timeout", 500);
    chk("rerun_pulses", pulse_cnt - base, 3);
    chk("rerun_px0", {8'd0, pix_log[base]}, 32'h102030);
    chk("rerun_no_latch", {31'd0, latch_log[base+2]}, 32'd0);

    // Brightness
    wr(4'd2, 8'hFF); wr(4'd3, 8'h80); wr(4'd4, 8'h02);
    wr(4'd5, 8'd1);
    wr(4'd6, 8'h7F);
    base = pulse_cnt;
    wr(4'd0, 8'h03);
    wait_idle("bright_timeout", 200);
    chk("bright_pulses", pulse_cnt - base, 1);
    chk("bright_latch", {31'd0, latch_log[base]}, 32'd1);
`ifdef WS_SEQ_BRIGHTNESS_EN
    rd(4'd6, rv); chk("bright_reg", {24'd0, rv}, 32'h7F);
    chk("bright_px", {8'd0, pix_log[base]}, 32'h7F4001);
`else
    rd(4'd6, rv); chk("bright_reg", {24'd0, rv}, 32'h00);
    chk("bright_px", {8'd0, pix_log[base]}, 32'hFF8002);
`endif

    // Reset during WAIT_BUSY of the 2nd pixel
    wr(4'd5, 8'd3);
    base = pulse_cnt;
    wr(4'd0, 8'h01);
    wait_pulses("rst_wait2", base + 2, 500);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, px_valid}, 32'd0);
    chk("midrst_latch", {31'd0, px_latch}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rd(4'd0, rv); chk("midrst_ctrl", {24'd0, rv}, 32'h00);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_more", pulse_cnt - base, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
